// File: rtl/dbi_tx_sequencer_if.sv
// Host, pixel and PHY request bundle around the DBI transmit sequencer.
// Latency: none, signal container only.
// Backpressure: valid/ready on every channel; ready flows from the PHY upstream.
interface dbi_tx_sequencer_if #(
    parameter int DBI_IF_D_W = 8
);
    // host command channel
    logic [DBI_IF_D_W-1:0] host_typ_i;
    logic [DBI_IF_D_W-1:0] host_dat_i;
    logic                  host_no_dat_i;
    logic                  host_last_i;
    logic                  host_vld_i;
    logic                  host_rdy_o;
    // pixel stream channel
    logic [DBI_IF_D_W-1:0] pxl_dat_i;
    logic                  pxl_last_i;
    logic                  pxl_vld_i;
    logic                  pxl_rdy_o;
    // PHY request channel
    logic                  dtf_dbi_hrst_o;
    logic                  dtf_tx_no_dat_o;
    logic                  dtf_tx_last_o;
    logic                  dtf_tx_vld_o;
    logic [DBI_IF_D_W-1:0] dtf_tx_cmd_typ_o;
    logic [DBI_IF_D_W-1:0] dtf_tx_cmd_dat_o;
    logic                  dtf_tx_rdy_i;

    // sequencer side: consumes host/pixel traffic, drives the PHY
    modport master (
        input  host_typ_i, host_dat_i, host_no_dat_i, host_last_i, host_vld_i,
        output host_rdy_o,
        input  pxl_dat_i, pxl_last_i, pxl_vld_i,
        output pxl_rdy_o,
        output dtf_dbi_hrst_o, dtf_tx_no_dat_o, dtf_tx_last_o, dtf_tx_vld_o,
        output dtf_tx_cmd_typ_o, dtf_tx_cmd_dat_o,
        input  dtf_tx_rdy_i
    );

    // environment side: host, pixel source and PHY
    modport slave (
        output host_typ_i, host_dat_i, host_no_dat_i, host_last_i, host_vld_i,
        input  host_rdy_o,
        output pxl_dat_i, pxl_last_i, pxl_vld_i,
        input  pxl_rdy_o,
        input  dtf_dbi_hrst_o, dtf_tx_no_dat_o, dtf_tx_last_o, dtf_tx_vld_o,
        input  dtf_tx_cmd_typ_o, dtf_tx_cmd_dat_o,
        output dtf_tx_rdy_i
    );
endinterface

// File: rtl/dbi_tx_sequencer.sv
// DBI panel sequencer: runs the power-up command script, then arbitrates host commands and pixel frames onto the PHY.
// Latency: PHY request is combinational from host/pixel inputs; one READY cycle between transactions.
// Backpressure: dtf_tx_rdy_i passes straight back to the active source; all dtf_* fields hold while stalled.
module dbi_tx_sequencer #(
    parameter int         DBI_IF_D_W   = 8,
    parameter int         RST_WAIT_CYC = 16,
    parameter int         SLP_WAIT_CYC = 16,
    parameter logic [7:0] PIX_FMT      = 8'h05
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    output logic               init_done_o,
    output logic               busy_o,
    dbi_tx_sequencer_if.master bus
);

    localparam int WAIT_MAX = (RST_WAIT_CYC > SLP_WAIT_CYC) ? RST_WAIT_CYC : SLP_WAIT_CYC;
    localparam int CNT_W    = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;

    localparam logic [CNT_W-1:0] RST_LD = CNT_W'((RST_WAIT_CYC > 0) ? RST_WAIT_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] SLP_LD = CNT_W'((SLP_WAIT_CYC > 0) ? SLP_WAIT_CYC - 1 : 0);

    localparam logic [DBI_IF_D_W-1:0] CMD_SLPOUT = DBI_IF_D_W'(8'h11);
    localparam logic [DBI_IF_D_W-1:0] CMD_COLMOD = DBI_IF_D_W'(8'h3A);
    localparam logic [DBI_IF_D_W-1:0] CMD_DISPON = DBI_IF_D_W'(8'h29);
    localparam logic [DBI_IF_D_W-1:0] CMD_RAMWR  = DBI_IF_D_W'(8'h2C);
    localparam logic [DBI_IF_D_W-1:0] COL_FMT    = DBI_IF_D_W'(PIX_FMT);

    typedef enum logic [3:0] {
        IDLE,
        INIT_HRST,
        INIT_RW,
        INIT_SLP,
        INIT_SW,
        INIT_COL,
        INIT_ON,
        READY,
        HOST,
        FRM
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             first, first_nxt;      // next beat of the open transaction is its first
    logic             init_done, init_done_nxt;
    logic             xfer;

    assign xfer        = bus.dtf_tx_vld_o & bus.dtf_tx_rdy_i;
    assign init_done_o = init_done;
    assign busy_o      = (state != IDLE) && (state != READY);

    // state, wait counter, first-beat flag and init-done flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            first     <= 1'b0;
            init_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            first     <= first_nxt;
            init_done <= init_done_nxt;
        end
    end

    // next-state logic and PHY request / source ready generation
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        first_nxt     = first;
        init_done_nxt = init_done;

        bus.dtf_dbi_hrst_o   = 1'b0;
        bus.dtf_tx_no_dat_o  = 1'b0;
        bus.dtf_tx_last_o    = 1'b0;
        bus.dtf_tx_vld_o     = 1'b0;
        bus.dtf_tx_cmd_typ_o = '0;
        bus.dtf_tx_cmd_dat_o = '0;
        bus.host_rdy_o       = 1'b0;
        bus.pxl_rdy_o        = 1'b0;

        case (state)
            IDLE: begin
                if (start_i) state_nxt = INIT_HRST;
            end

            INIT_HRST: begin
                bus.dtf_tx_vld_o   = 1'b1;
                bus.dtf_dbi_hrst_o = 1'b1;
                if (xfer) begin
                    cnt_nxt   = RST_LD;
                    state_nxt = INIT_RW;
                end
            end

            INIT_RW: begin
                if (cnt == '0) state_nxt = INIT_SLP;
                else           cnt_nxt   = cnt - 1'b1;
            end

            INIT_SLP: begin
                bus.dtf_tx_vld_o     = 1'b1;
                bus.dtf_tx_cmd_typ_o = CMD_SLPOUT;
                bus.dtf_tx_no_dat_o  = 1'b1;
                bus.dtf_tx_last_o    = 1'b1;
                if (xfer) begin
                    cnt_nxt   = SLP_LD;
                    state_nxt = INIT_SW;
                end
            end

            INIT_SW: begin
                if (cnt == '0) state_nxt = INIT_COL;
                else           cnt_nxt   = cnt - 1'b1;
            end

            INIT_COL: begin
                bus.dtf_tx_vld_o     = 1'b1;
                bus.dtf_tx_cmd_typ_o = CMD_COLMOD;
                bus.dtf_tx_cmd_dat_o = COL_FMT;
                bus.dtf_tx_last_o    = 1'b1;
                if (xfer) state_nxt = INIT_ON;
            end

            INIT_ON: begin
                bus.dtf_tx_vld_o     = 1'b1;
                bus.dtf_tx_cmd_typ_o = CMD_DISPON;
                bus.dtf_tx_no_dat_o  = 1'b1;
                bus.dtf_tx_last_o    = 1'b1;
                if (xfer) begin
                    init_done_nxt = 1'b1;
                    state_nxt     = READY;
                end
            end

            READY: begin
                // host has priority; a restart is only honoured with both sources quiet
                if (bus.host_vld_i) begin
                    first_nxt = 1'b1;
                    state_nxt = HOST;
                end else if (bus.pxl_vld_i) begin
                    first_nxt = 1'b1;
                    state_nxt = FRM;
                end else if (start_i) begin
                    init_done_nxt = 1'b0;
                    state_nxt     = INIT_HRST;
                end
            end

            HOST: begin
                bus.dtf_tx_vld_o     = bus.host_vld_i;
                bus.host_rdy_o       = bus.dtf_tx_rdy_i;
                bus.dtf_tx_cmd_typ_o = first ? bus.host_typ_i : '0;
                bus.dtf_tx_no_dat_o  = first & bus.host_no_dat_i;
                bus.dtf_tx_cmd_dat_o = bus.host_dat_i;
                bus.dtf_tx_last_o    = bus.host_last_i;
                if (xfer) begin
                    first_nxt = 1'b0;
                    if (bus.host_last_i || (first && bus.host_no_dat_i)) state_nxt = READY;
                end
            end

            FRM: begin
                bus.dtf_tx_vld_o     = bus.pxl_vld_i;
                bus.pxl_rdy_o        = bus.dtf_tx_rdy_i;
                bus.dtf_tx_cmd_typ_o = first ? CMD_RAMWR : '0;
                bus.dtf_tx_cmd_dat_o = bus.pxl_dat_i;
                bus.dtf_tx_last_o    = bus.pxl_last_i;
                if (xfer) begin
                    first_nxt = 1'b0;
                    if (bus.pxl_last_i) state_nxt = READY;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dbi_tx_sequencer.sv
// Bench for the DBI transmit sequencer: reset, init script timing, cycle table, stall, restart guard, random traffic, mid-frame reset.
// Latency: expectations are per cycle for the table, per beat (with cycle stamps) elsewhere.
// Backpressure: PHY ready is driven as fixed patterns or randomly; sources hold until accepted.
`timescale 1ns/1ps
module tb_dbi_tx_sequencer;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_i = 1'b0;
    logic init_done_o;
    logic busy_o;

    dbi_tx_sequencer_if #(.DBI_IF_D_W(W)) bus ();

    dbi_tx_sequencer #(
        .DBI_IF_D_W  (W),
        .RST_WAIT_CYC(16),
        .SLP_WAIT_CYC(16),
        .PIX_FMT     (8'h05)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .init_done_o(init_done_o),
        .busy_o     (busy_o),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // beat fields {hrst, typ, dat, no_dat, last}
    function automatic logic [18:0] bf(input logic h, input logic [7:0] t, input logic [7:0] d,
                                       input logic n, input logic l);
        return {h, t, d, n, l};
    endfunction

    function automatic logic [18:0] cur_f();
        return {bus.dtf_dbi_hrst_o, bus.dtf_tx_cmd_typ_o, bus.dtf_tx_cmd_dat_o,
                bus.dtf_tx_no_dat_o, bus.dtf_tx_last_o};
    endfunction

    // whole observable output picture {vld, beat fields, host_rdy, pxl_rdy, busy, init_done}
    function automatic logic [23:0] outv();
        return {bus.dtf_tx_vld_o, cur_f(), bus.host_rdy_o, bus.pxl_rdy_o, busy_o, init_done_o};
    endfunction

    function automatic logic [23:0] ov(input logic v, input logic h, input logic [7:0] t,
                                       input logic [7:0] d, input logic n, input logic l,
                                       input logic hr, input logic pr, input logic b, input logic dn);
        return {v, h, t, d, n, l, hr, pr, b, dn};
    endfunction

    // ---------------- beat monitor and hold checker ----------------
    typedef struct {
        int          cyc;
        int          src;   // 0 none, 1 host, 2 pixel
        logic [18:0] f;
    } beat_t;

    beat_t       beat_q[$];
    logic [19:0] prev_vf;
    logic        prev_stall = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) check("hold_while_stalled", {bus.dtf_tx_vld_o, cur_f()}, prev_vf);
            if (bus.dtf_tx_vld_o && bus.dtf_tx_rdy_i) begin
                beat_t b;
                b.cyc = cyc;
                b.src = bus.host_rdy_o ? 1 : (bus.pxl_rdy_o ? 2 : 0);
                b.f   = cur_f();
                beat_q.push_back(b);
            end
            prev_stall = bus.dtf_tx_vld_o && !bus.dtf_tx_rdy_i;
            prev_vf    = {bus.dtf_tx_vld_o, cur_f()};
        end
    end

    // ---------------- source drivers (called at posedge+1, return at posedge+1) ----------------
    task automatic host_send(input logic [7:0] t, input logic [7:0] d, input logic n, input logic l);
        int   tmo = 0;
        logic ok  = 1'b0;
        bus.host_vld_i = 1'b1; bus.host_typ_i = t; bus.host_dat_i = d;
        bus.host_no_dat_i = n; bus.host_last_i = l;
        while (!ok && tmo < 100) begin
            @(negedge clk); ok = bus.host_rdy_o;
            @(posedge clk); #1; tmo++;
        end
        check("host_handshake", ok, 1);
    endtask

    task automatic pxl_send(input logic [7:0] d, input logic l);
        int   tmo = 0;
        logic ok  = 1'b0;
        bus.pxl_vld_i = 1'b1; bus.pxl_dat_i = d; bus.pxl_last_i = l;
        while (!ok && tmo < 100) begin
            @(negedge clk); ok = bus.pxl_rdy_o;
            @(posedge clk); #1; tmo++;
        end
        check("pxl_handshake", ok, 1);
    endtask

    // ---------------- reference model for random traffic ----------------
    typedef struct {
        logic [18:0] f;
        logic        eot;
    } exp_t;

    exp_t exp_h[$];
    exp_t exp_p[$];
    logic drv_done = 1'b0;

    task automatic host_drv(input int ncmd);
        @(posedge clk); #1;
        for (int c = 0; c < ncmd; c++) begin
            logic       nd;
            int         len;
            logic [7:0] typ;
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            nd  = ($urandom_range(0, 3) == 0);
            len = nd ? 1 : $urandom_range(1, 4);
            typ = 8'($urandom_range(0, 255));
            for (int b = 0; b < len; b++) begin
                logic [7:0] d;
                logic       l;
                exp_t       e;
                d = 8'($urandom_range(0, 255));
                l = nd ? 1'($urandom_range(0, 1)) : (b == len - 1);
                // command byte and no-data flag only ride on the opening beat
                e.f   = (b == 0) ? bf(1'b0, typ, d, nd, l) : bf(1'b0, 8'h00, d, 1'b0, l);
                e.eot = (b == len - 1);
                exp_h.push_back(e);
                host_send((b == 0) ? typ : 8'($urandom_range(0, 255)), d, nd && (b == 0), l);
            end
            bus.host_vld_i = 1'b0;
        end
    endtask

    task automatic pxl_drv(input int nfrm);
        @(posedge clk); #1;
        for (int f = 0; f < nfrm; f++) begin
            int len;
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            len = $urandom_range(1, 5);
            for (int b = 0; b < len; b++) begin
                logic [7:0] d;
                exp_t       e;
                d     = 8'($urandom_range(0, 255));
                e.f   = bf(1'b0, (b == 0) ? 8'h2C : 8'h00, d, 1'b0, b == len - 1);
                e.eot = (b == len - 1);
                exp_p.push_back(e);
                pxl_send(d, b == len - 1);
            end
            bus.pxl_vld_i = 1'b0;
        end
    endtask

    // ---------------- cycle table ----------------
    typedef struct {
        logic        hv;
        logic [7:0]  ht;
        logic [7:0]  hd;
        logic        hn;
        logic        hl;
        logic        pv;
        logic [7:0]  pd;
        logic        pl;
        logic        rdy;
        logic [23:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic hv, input logic [7:0] ht, input logic [7:0] hd, input logic hn,
                       input logic hl, input logic pv, input logic [7:0] pd, input logic pl,
                       input logic rdy, input logic [23:0] exp);
        vec_t v;
        v.hv = hv; v.ht = ht; v.hd = hd; v.hn = hn; v.hl = hl;
        v.pv = pv; v.pd = pd; v.pl = pl; v.rdy = rdy; v.exp = exp;
        tbl.push_back(v);
    endtask

    initial begin
        logic [23:0] rdy_idle;
        logic [23:0] held;
        int          tmo;
        int          open_src;

        bus.host_typ_i = '0; bus.host_dat_i = '0; bus.host_no_dat_i = 1'b0;
        bus.host_last_i = 1'b0; bus.host_vld_i = 1'b0;
        bus.pxl_dat_i = '0; bus.pxl_last_i = 1'b0; bus.pxl_vld_i = 1'b0;
        bus.dtf_tx_rdy_i = 1'b1;

        // ---- reset state and quiet IDLE ----
        @(negedge clk);
        check("reset_outputs", outv(), 24'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.host_vld_i = 1'b1; bus.host_typ_i = 8'h2A; bus.pxl_vld_i = 1'b1; bus.pxl_dat_i = 8'h77;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_quiet", outv(), 24'h0);
            @(posedge clk); #1;
        end
        check("idle_no_beats", beat_q.size(), 0);
        bus.host_vld_i = 1'b0; bus.pxl_vld_i = 1'b0;

        // ---- init script ----
        beat_q.delete();
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        @(negedge clk);
        check("init_busy", busy_o, 1);
        tmo = 0;
        while (!init_done_o && tmo < 200) begin
            @(negedge clk); tmo++;
        end
        check("init_done", init_done_o, 1);
        check("init_beat_count", beat_q.size(), 4);
        if (beat_q.size() >= 4) begin
            check("init_hrst_beat",   beat_q[0].f, bf(1'b1, 8'h00, 8'h00, 1'b0, 1'b0));
            check("init_slpout_beat", beat_q[1].f, bf(1'b0, 8'h11, 8'h00, 1'b1, 1'b1));
            check("init_colmod_beat", beat_q[2].f, bf(1'b0, 8'h3A, 8'h05, 1'b0, 1'b1));
            check("init_dispon_beat", beat_q[3].f, bf(1'b0, 8'h29, 8'h00, 1'b1, 1'b1));
            check("init_gap_reset", beat_q[1].cyc - beat_q[0].cyc, 17);
            check("init_gap_sleep", beat_q[2].cyc - beat_q[1].cyc, 17);
            check("init_gap_on",    beat_q[3].cyc - beat_q[2].cyc, 1);
        end

        // ---- per-cycle table from READY ----
        rdy_idle = ov(0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1);
        add(0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 1, rdy_idle);
        add(1, 8'h01, 8'h00, 1, 0, 0, 8'h00, 0, 1, rdy_idle);
        add(1, 8'h01, 8'h00, 1, 0, 0, 8'h00, 0, 1, ov(1, 0, 8'h01, 8'h00, 1, 0, 1, 0, 1, 1));
        add(0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 1, rdy_idle);
        add(0, 8'h00, 8'h00, 0, 0, 1, 8'hA1, 0, 1, rdy_idle);
        add(0, 8'h00, 8'h00, 0, 0, 1, 8'hA1, 0, 1, ov(1, 0, 8'h2C, 8'hA1, 0, 0, 0, 1, 1, 1));
        add(0, 8'h00, 8'h00, 0, 0, 1, 8'hA2, 0, 1, ov(1, 0, 8'h00, 8'hA2, 0, 0, 0, 1, 1, 1));
        add(0, 8'h00, 8'h00, 0, 0, 1, 8'hA3, 1, 0, ov(1, 0, 8'h00, 8'hA3, 0, 1, 0, 0, 1, 1));
        add(0, 8'h00, 8'h00, 0, 0, 1, 8'hA3, 1, 1, ov(1, 0, 8'h00, 8'hA3, 0, 1, 0, 1, 1, 1));
        add(0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 1, rdy_idle);
        add(1, 8'h2A, 8'h00, 0, 0, 1, 8'hA1, 1, 1, rdy_idle);
        add(1, 8'h2A, 8'h00, 0, 0, 1, 8'hA1, 1, 1, ov(1, 0, 8'h2A, 8'h00, 0, 0, 1, 0, 1, 1));
        add(1, 8'h55, 8'h10, 0, 1, 1, 8'hA1, 1, 1, ov(1, 0, 8'h00, 8'h10, 0, 1, 1, 0, 1, 1));
        add(0, 8'h00, 8'h00, 0, 0, 1, 8'hA1, 1, 1, rdy_idle);
        add(0, 8'h00, 8'h00, 0, 0, 1, 8'hA1, 1, 1, ov(1, 0, 8'h2C, 8'hA1, 0, 1, 0, 1, 1, 1));
        add(0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 1, rdy_idle);
        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk); #1;
            bus.host_vld_i = tbl[i].hv; bus.host_typ_i = tbl[i].ht; bus.host_dat_i = tbl[i].hd;
            bus.host_no_dat_i = tbl[i].hn; bus.host_last_i = tbl[i].hl;
            bus.pxl_vld_i = tbl[i].pv; bus.pxl_dat_i = tbl[i].pd; bus.pxl_last_i = tbl[i].pl;
            bus.dtf_tx_rdy_i = tbl[i].rdy;
            @(negedge clk);
            check($sformatf("table_row_%0d", i), outv(), tbl[i].exp);
        end

        // ---- 5-cycle PHY stall mid-frame, with an ignored start pulse ----
        @(posedge clk); #1;
        beat_q.delete();
        pxl_send(8'hB1, 1'b0);
        bus.pxl_dat_i = 8'hB2; bus.pxl_last_i = 1'b0;
        bus.dtf_tx_rdy_i = 1'b0;
        start_i = 1'b1;
        held = ov(1, 0, 8'h00, 8'hB2, 0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_outputs", outv(), held);
            @(posedge clk); #1;
            start_i = 1'b0;
        end
        bus.dtf_tx_rdy_i = 1'b1;
        pxl_send(8'hB2, 1'b0);
        pxl_send(8'hB3, 1'b0);
        pxl_send(8'hB4, 1'b1);
        bus.pxl_vld_i = 1'b0;
        @(negedge clk);
        check("stall_beat_count", beat_q.size(), 4);
        if (beat_q.size() >= 4) begin
            check("stall_beat0", beat_q[0].f, bf(0, 8'h2C, 8'hB1, 0, 0));
            check("stall_beat1", beat_q[1].f, bf(0, 8'h00, 8'hB2, 0, 0));
            check("stall_beat2", beat_q[2].f, bf(0, 8'h00, 8'hB3, 0, 0));
            check("stall_beat3", beat_q[3].f, bf(0, 8'h00, 8'hB4, 0, 1));
        end
        check("start_ignored_in_frame", {busy_o, init_done_o}, 2'b01);

        // ---- random traffic against the transaction-level model ----
        @(posedge clk); #1;
        beat_q.delete();
        fork
            begin
                fork
                    host_drv(12);
                    pxl_drv(12);
                join
                drv_done = 1'b1;
            end
            begin
                while (!drv_done) begin
                    @(posedge clk); #1;
                    bus.dtf_tx_rdy_i = ($urandom_range(0, 9) < 7);
                end
                bus.dtf_tx_rdy_i = 1'b1;
            end
        join
        @(negedge clk);
        open_src = 0;
        foreach (beat_q[i]) begin
            exp_t e;
            if (open_src != 0) check("rnd_no_interleave", beat_q[i].src, open_src);
            if (beat_q[i].src == 1 && exp_h.size() > 0) begin
                e = exp_h.pop_front();
                check("rnd_host_beat", beat_q[i].f, e.f);
                open_src = e.eot ? 0 : 1;
            end else if (beat_q[i].src == 2 && exp_p.size() > 0) begin
                e = exp_p.pop_front();
                check("rnd_pxl_beat", beat_q[i].f, e.f);
                open_src = e.eot ? 0 : 2;
            end else begin
                check("rnd_unexpected_beat", beat_q[i].src, 3);
            end
        end
        check("rnd_host_left", exp_h.size(), 0);
        check("rnd_pxl_left", exp_p.size(), 0);
        check("rnd_back_ready", {busy_o, init_done_o}, 2'b01);

        // ---- asynchronous reset in the middle of a frame ----
        @(posedge clk); #1;
        pxl_send(8'hC1, 1'b0);
        bus.pxl_dat_i = 8'hC2;
        #1 rst = 1'b1;
        #1 check("rst_mid_frame", outv(), 24'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        beat_q.delete();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_pixels_ignored", outv(), 24'h0);
            @(posedge clk); #1;
        end
        check("post_rst_no_beats", beat_q.size(), 0);
        bus.pxl_vld_i = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
